// File: rtl/prach_c_plane_tx_if.sv
// Handshake bundles for prach_c_plane_tx: scheduler request port and
// single-beat Avalon-ST C-plane field source toward the framer.
interface prach_req_if;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_cc;
  logic [7:0]  req_ant_mask;
  logic [7:0]  req_frameId;
  logic [3:0]  req_subframeId;
  logic [5:0]  req_slotId;
  logic [5:0]  req_symbolId;
  logic [15:0] req_timeOffset;
  logic [15:0] req_cpLength;
  logic [11:0] req_sectionId;
  logic [9:0]  req_startPrbc;
  logic [7:0]  req_numPrbc;
  logic [3:0]  req_numSymbol;
  logic [14:0] req_beamid;
  logic [23:0] req_freqOffset;

  modport master (
    output req_valid, req_cc, req_ant_mask, req_frameId, req_subframeId, req_slotId,
           req_symbolId, req_timeOffset, req_cpLength, req_sectionId, req_startPrbc,
           req_numPrbc, req_numSymbol, req_beamid, req_freqOffset,
    input  req_ready
  );
  modport slave (
    input  req_valid, req_cc, req_ant_mask, req_frameId, req_subframeId, req_slotId,
           req_symbolId, req_timeOffset, req_cpLength, req_sectionId, req_startPrbc,
           req_numPrbc, req_numSymbol, req_beamid, req_freqOffset,
    output req_ready
  );
endinterface

interface prach_c_if;
  logic        avst_source_c_valid;
  logic        avst_source_c_ready;
  logic        avst_source_c_startofpacket;
  logic        avst_source_c_endofpacket;
  logic [15:0] tx_c_rtc_id;
  logic [15:0] tx_c_seq_id;
  logic        tx_c_dataDirection;
  logic [2:0]  tx_c_payloadVersion;
  logic [3:0]  tx_c_filterIndex;
  logic [7:0]  tx_c_sectionType;
  logic [7:0]  tx_c_frameId;
  logic [3:0]  tx_c_subframeId;
  logic [5:0]  tx_c_slotId;
  logic [5:0]  tx_c_symbolId;
  logic [15:0] tx_c_timeOffset;
  logic [15:0] tx_c_cpLength;
  logic [11:0] tx_c_sectionId;
  logic [9:0]  tx_c_startPrbc;
  logic [7:0]  tx_c_numPrbc;
  logic [3:0]  tx_c_numSymbol;
  logic [14:0] tx_c_beamid;
  logic [23:0] tx_c_freqOffset;
  logic [7:0]  tx_c_frameStructure;
  logic [7:0]  tx_c_udCompHdr;
  logic        tx_c_rb;
  logic        tx_c_symInc;
  logic        tx_c_ef;
  logic [11:0] tx_c_reMask;

  modport master (
    output avst_source_c_valid, avst_source_c_startofpacket, avst_source_c_endofpacket,
           tx_c_rtc_id, tx_c_seq_id, tx_c_dataDirection, tx_c_payloadVersion,
           tx_c_filterIndex, tx_c_sectionType, tx_c_frameId, tx_c_subframeId, tx_c_slotId,
           tx_c_symbolId, tx_c_timeOffset, tx_c_cpLength, tx_c_sectionId, tx_c_startPrbc,
           tx_c_numPrbc, tx_c_numSymbol, tx_c_beamid, tx_c_freqOffset, tx_c_frameStructure,
           tx_c_udCompHdr, tx_c_rb, tx_c_symInc, tx_c_ef, tx_c_reMask,
    input  avst_source_c_ready
  );
  modport slave (
    input  avst_source_c_valid, avst_source_c_startofpacket, avst_source_c_endofpacket,
           tx_c_rtc_id, tx_c_seq_id, tx_c_dataDirection, tx_c_payloadVersion,
           tx_c_filterIndex, tx_c_sectionType, tx_c_frameId, tx_c_subframeId, tx_c_slotId,
           tx_c_symbolId, tx_c_timeOffset, tx_c_cpLength, tx_c_sectionId, tx_c_startPrbc,
           tx_c_numPrbc, tx_c_numSymbol, tx_c_beamid, tx_c_freqOffset, tx_c_frameStructure,
           tx_c_udCompHdr, tx_c_rb, tx_c_symInc, tx_c_ef, tx_c_reMask,
    output avst_source_c_ready
  );
endinterface

// File: rtl/prach_c_plane_tx.sv
// PRACH (Section Type 3) C-plane transmitter: expands one scheduler request
// over its antenna mask into one single-beat field message per antenna.
module prach_c_plane_tx #(
  parameter logic [7:0] FRAME_STRUCTURE = 8'hC1,
  parameter logic [7:0] UD_COMP_HDR     = 8'h00,
  parameter logic [2:0] PAYLOAD_VERSION = 3'd1
) (
  input  logic        clk,
  input  logic        rst,
  prach_req_if.slave  req,
  prach_c_if.master   src,
  output logic        err_bad_cc
);
  localparam int unsigned N_CNT = 24;

  typedef enum logic {IDLE, SEND} state_t;

  state_t     state;
  logic [7:0] mask_q;
  logic [1:0] cc_q;
  logic [2:0] cur_ant;
  logic [7:0] seq_cnt [N_CNT];

  logic [7:0]  rest_mask;
  logic [7:0]  ld_mask;
  logic [1:0]  ld_cc;
  logic [2:0]  ld_ant;
  logic [4:0]  ld_idx;
  logic [15:0] ld_seq;

  function automatic logic [2:0] low_ant(input logic [7:0] m);
    low_ant = 3'd0;
    for (int i = 7; i >= 0; i--) if (m[i]) low_ant = 3'(i);
  endfunction

  // DU_ID=0 | Band_Sector=ant[2] | CC_ID=cc | Ant_ID=ant[1:0]
  function automatic logic [15:0] rtc_of(input logic [1:0] cc, input logic [2:0] a);
    rtc_of = {7'd0, a[2], 2'd0, cc, 2'd0, a[1:0]};
  endfunction

  // Next antenna to present: first of a new request, or next after a handshake.
  always_comb begin
    rest_mask = mask_q & (mask_q - 8'd1);
    ld_mask   = rest_mask;
    ld_cc     = cc_q;
    if (state == IDLE) begin
      ld_mask = req.req_ant_mask;
      ld_cc   = req.req_cc;
    end
    ld_ant = low_ant(ld_mask);
    ld_idx = (ld_cc == 2'd3) ? 5'd0 : {ld_cc, ld_ant};
    ld_seq = {seq_cnt[ld_idx], 1'b1, 7'd0};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state                           <= IDLE;
      req.req_ready                   <= 1'b0;
      err_bad_cc                      <= 1'b0;
      mask_q                          <= '0;
      cc_q                            <= '0;
      cur_ant                         <= '0;
      for (int i = 0; i < N_CNT; i++) seq_cnt[i] <= '0;
      src.avst_source_c_valid         <= 1'b0;
      src.avst_source_c_startofpacket <= 1'b0;
      src.avst_source_c_endofpacket   <= 1'b0;
      src.tx_c_rtc_id                 <= '0;
      src.tx_c_seq_id                 <= '0;
      src.tx_c_dataDirection          <= '0;
      src.tx_c_payloadVersion         <= '0;
      src.tx_c_filterIndex            <= '0;
      src.tx_c_sectionType            <= '0;
      src.tx_c_frameId                <= '0;
      src.tx_c_subframeId             <= '0;
      src.tx_c_slotId                 <= '0;
      src.tx_c_symbolId               <= '0;
      src.tx_c_timeOffset             <= '0;
      src.tx_c_cpLength               <= '0;
      src.tx_c_sectionId              <= '0;
      src.tx_c_startPrbc              <= '0;
      src.tx_c_numPrbc                <= '0;
      src.tx_c_numSymbol              <= '0;
      src.tx_c_beamid                 <= '0;
      src.tx_c_freqOffset             <= '0;
      src.tx_c_frameStructure         <= '0;
      src.tx_c_udCompHdr              <= '0;
      src.tx_c_rb                     <= '0;
      src.tx_c_symInc                 <= '0;
      src.tx_c_ef                     <= '0;
      src.tx_c_reMask                 <= '0;
    end else begin
      err_bad_cc <= 1'b0;
      if (state == IDLE) begin
        req.req_ready <= 1'b1;
        if (req.req_valid && req.req_ready) begin
          if (req.req_cc == 2'd3) begin
            err_bad_cc <= 1'b1;
          end else if (req.req_ant_mask != 8'd0) begin
            state                           <= SEND;
            req.req_ready                   <= 1'b0;
            mask_q                          <= req.req_ant_mask;
            cc_q                            <= req.req_cc;
            cur_ant                         <= ld_ant;
            src.avst_source_c_valid         <= 1'b1;
            src.avst_source_c_startofpacket <= 1'b1;
            src.avst_source_c_endofpacket   <= 1'b1;
            src.tx_c_rtc_id                 <= rtc_of(req.req_cc, ld_ant);
            src.tx_c_seq_id                 <= ld_seq;
            src.tx_c_dataDirection          <= 1'b0;
            src.tx_c_payloadVersion         <= PAYLOAD_VERSION;
            src.tx_c_filterIndex            <= 4'b0001;
            src.tx_c_sectionType            <= 8'd3;
            src.tx_c_frameId                <= req.req_frameId;
            src.tx_c_subframeId             <= req.req_subframeId;
            src.tx_c_slotId                 <= req.req_slotId;
            src.tx_c_symbolId               <= req.req_symbolId;
            src.tx_c_timeOffset             <= req.req_timeOffset;
            src.tx_c_cpLength               <= req.req_cpLength;
            src.tx_c_sectionId              <= req.req_sectionId;
            src.tx_c_startPrbc              <= req.req_startPrbc;
            src.tx_c_numPrbc                <= req.req_numPrbc;
            src.tx_c_numSymbol              <= req.req_numSymbol;
            src.tx_c_beamid                 <= req.req_beamid;
            src.tx_c_freqOffset             <= req.req_freqOffset;
            src.tx_c_frameStructure         <= FRAME_STRUCTURE;
            src.tx_c_udCompHdr              <= UD_COMP_HDR;
            src.tx_c_rb                     <= 1'b0;
            src.tx_c_symInc                 <= 1'b0;
            src.tx_c_ef                     <= 1'b0;
            src.tx_c_reMask                 <= 12'hFFF;
          end
        end
      end else if (src.avst_source_c_valid && src.avst_source_c_ready) begin
        // Handshake: retire this antenna, then present the next or finish.
        seq_cnt[{cc_q, cur_ant}] <= seq_cnt[{cc_q, cur_ant}] + 8'd1;
        mask_q                   <= rest_mask;
        if (rest_mask == 8'd0) begin
          state                           <= IDLE;
          req.req_ready                   <= 1'b1;
          src.avst_source_c_valid         <= 1'b0;
          src.avst_source_c_startofpacket <= 1'b0;
          src.avst_source_c_endofpacket   <= 1'b0;
        end else begin
          cur_ant         <= ld_ant;
          src.tx_c_rtc_id <= rtc_of(cc_q, ld_ant);
          src.tx_c_seq_id <= ld_seq;
        end
      end
    end
  end
endmodule

// File: tb/tb_prach_c_plane_tx.sv
// Randomized self-checking bench for prach_c_plane_tx against a per-request
// message-list model with per-eAxC sequence counters.
module tb_prach_c_plane_tx;
  logic clk = 1'b0;
  logic rst;
  logic err;
  always #5 clk = ~clk;

  prach_req_if r ();
  prach_c_if   c ();

  prach_c_plane_tx dut (.clk(clk), .rst(rst), .req(r.slave), .src(c.master), .err_bad_cc(err));

  typedef struct {
    logic [1:0]  cc;   logic [7:0]  mask;
    logic [7:0]  frame; logic [3:0] sub; logic [5:0] slot; logic [5:0] sym;
    logic [15:0] toff; logic [15:0] cp;  logic [11:0] sid; logic [9:0] sp;
    logic [7:0]  np;   logic [3:0]  ns;  logic [14:0] bm;  logic [23:0] fo;
  } req_t;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int unsigned mcnt [3][8];
  logic [255:0] exp_q [$];
  logic [255:0] got_q [$];
  logic [15:0]  got_rtc [$];
  logic [15:0]  got_seq [$];
  int           got_idx [$];
  int           unstable;
  bit           timeout, after_ready, after_valid;

  function automatic req_t rand_req(input logic [1:0] cc, input logic [7:0] mask);
    req_t q;
    q.cc = cc; q.mask = mask;
    q.frame = 8'($urandom); q.sub = 4'($urandom); q.slot = 6'($urandom); q.sym = 6'($urandom);
    q.toff = 16'($urandom); q.cp = 16'($urandom); q.sid = 12'($urandom); q.sp = 10'($urandom);
    q.np = 8'($urandom); q.ns = 4'($urandom); q.bm = 15'($urandom); q.fo = 24'($urandom);
    return q;
  endfunction

  function automatic logic [255:0] exp_snap(input req_t q, input logic [15:0] rtc, input logic [15:0] seq);
    return 256'({rtc, seq, 1'b0, 3'd1, 4'd1, 8'd3, q.frame, q.sub, q.slot, q.sym, q.toff, q.cp,
                 q.sid, q.sp, q.np, q.ns, q.bm, q.fo, 8'hC1, 8'h00, 3'b000, 12'hFFF, 2'b11});
  endfunction

  function automatic logic [255:0] dut_snap();
    return 256'({c.tx_c_rtc_id, c.tx_c_seq_id, c.tx_c_dataDirection, c.tx_c_payloadVersion,
                 c.tx_c_filterIndex, c.tx_c_sectionType, c.tx_c_frameId, c.tx_c_subframeId,
                 c.tx_c_slotId, c.tx_c_symbolId, c.tx_c_timeOffset, c.tx_c_cpLength,
                 c.tx_c_sectionId, c.tx_c_startPrbc, c.tx_c_numPrbc, c.tx_c_numSymbol,
                 c.tx_c_beamid, c.tx_c_freqOffset, c.tx_c_frameStructure, c.tx_c_udCompHdr,
                 c.tx_c_rb, c.tx_c_symInc, c.tx_c_ef, c.tx_c_reMask,
                 c.avst_source_c_startofpacket, c.avst_source_c_endofpacket});
  endfunction

  // Reference: one message per set mask bit, ascending antenna, counter before increment.
  function automatic void model_req(input req_t q);
    int unsigned a_rtc, a_seq;
    if (q.cc == 2'd3) return;
    for (int a = 0; a < 8; a++) begin
      if (q.mask[a]) begin
        a_rtc = (a / 4) * 256 + int'(q.cc) * 16 + (a % 4);
        a_seq = mcnt[q.cc][a] * 256 + 128;
        mcnt[q.cc][a] = (mcnt[q.cc][a] + 1) % 256;
        exp_q.push_back(exp_snap(q, 16'(a_rtc), 16'(a_seq)));
      end
    end
  endfunction

  task automatic send_req(input req_t q, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (r.req_ready) begin
        r.req_valid = 1'b1; r.req_cc = q.cc; r.req_ant_mask = q.mask;
        r.req_frameId = q.frame; r.req_subframeId = q.sub; r.req_slotId = q.slot;
        r.req_symbolId = q.sym; r.req_timeOffset = q.toff; r.req_cpLength = q.cp;
        r.req_sectionId = q.sid; r.req_startPrbc = q.sp; r.req_numPrbc = q.np;
        r.req_numSymbol = q.ns; r.req_beamid = q.bm; r.req_freqOffset = q.fo;
        ok = 1'b1;
      end
    end
    if (ok) begin
      @(posedge clk);
      #1 r.req_valid = 1'b0;
    end
  endtask

  // Capture accepted beats under a ready pattern (0 always, 1 toggle, 2 random).
  task automatic collect(input int n, input int mode, input int budget);
    logic [255:0] cur, prev;
    bit had, rr;
    int cnt;
    got_q.delete(); got_rtc.delete(); got_seq.delete(); got_idx.delete();
    unstable = 0; had = 1'b0; cnt = 0; prev = '0;
    for (int i = 0; i < budget && cnt < n; i++) begin
      @(negedge clk);
      rr = (mode == 0) ? 1'b1 : (mode == 1) ? ((i % 2) == 0) : 1'($urandom_range(0, 1));
      c.avst_source_c_ready = rr;
      cur = dut_snap();
      if (had && cur != prev) unstable++;
      had = 1'b0;
      if (c.avst_source_c_valid) begin
        if (rr) begin
          got_q.push_back(cur); got_rtc.push_back(c.tx_c_rtc_id);
          got_seq.push_back(c.tx_c_seq_id); got_idx.push_back(i); cnt++;
        end else begin
          prev = cur; had = 1'b1;
        end
      end
    end
    timeout = (cnt < n);
    @(negedge clk);
    after_ready = r.req_ready;
    after_valid = c.avst_source_c_valid;
    c.avst_source_c_ready = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    r.req_valid = 1'b0; r.req_cc = '0; r.req_ant_mask = '0;
    c.avst_source_c_ready = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++; if (r.req_ready !== 1'b0) begin n_fail++; $display("FAIL reset_req_ready got %b exp 0", r.req_ready); end
    n_checks++; if (c.avst_source_c_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b exp 0", c.avst_source_c_valid); end
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err got %b exp 0", err); end
    n_checks++; if (dut_snap() !== 256'd0) begin n_fail++; $display("FAIL reset_fields got %h exp 0", dut_snap()); end
    rst = 1'b0;
    @(negedge clk);
    n_checks++; if (r.req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_release_ready got %b exp 1", r.req_ready); end
  endtask

  task automatic test_basic();
    req_t q; bit ok;
    q = rand_req(2'd0, 8'h0F);
    model_req(q);
    send_req(q, ok);
    collect(4, 0, 20);
    n_checks++; if (!ok || timeout) begin n_fail++; $display("FAIL basic_handshake ok=%b timeout=%b exp ok=1 timeout=0", ok, timeout); end
    for (int k = 0; k < got_q.size(); k++) begin
      n_checks++; if (got_q[k] !== exp_q[k]) begin n_fail++; $display("FAIL basic_beat%0d got %h exp %h", k, got_q[k], exp_q[k]); end
      n_checks++; if (got_rtc[k] !== 16'(k) || got_seq[k] !== 16'h0080) begin n_fail++; $display("FAIL basic_ids%0d got %h/%h exp %h/0080", k, got_rtc[k], got_seq[k], k); end
      n_checks++; if (got_idx[k] !== k) begin n_fail++; $display("FAIL basic_timing%0d got cycle %0d exp %0d", k, got_idx[k], k); end
    end
    n_checks++; if (after_ready !== 1'b1 || after_valid !== 1'b0) begin n_fail++; $display("FAIL basic_done got ready=%b valid=%b exp 1/0", after_ready, after_valid); end
    exp_q.delete();
  endtask

  task automatic test_backpressure();
    req_t q; bit ok;
    for (int pass = 0; pass < 2; pass++) begin
      q = rand_req(2'd2, 8'hA0);
      model_req(q);
      send_req(q, ok);
      collect(2, 1, 20);
      n_checks++; if (!ok || timeout) begin n_fail++; $display("FAIL bp_handshake ok=%b timeout=%b exp 1/0", ok, timeout); end
      for (int k = 0; k < got_q.size(); k++) begin
        n_checks++; if (got_q[k] !== exp_q[k]) begin n_fail++; $display("FAIL bp_beat%0d got %h exp %h", k, got_q[k], exp_q[k]); end
      end
      n_checks++; if (got_rtc.size() == 2 && (got_rtc[0] !== 16'h0121 || got_rtc[1] !== 16'h0123 || got_idx[1] !== 2))
        begin n_fail++; $display("FAIL bp_rtc got %h,%h@%0d exp 0121,0123@2", got_rtc[0], got_rtc[1], got_idx[1]); end
      n_checks++; if (unstable !== 0) begin n_fail++; $display("FAIL bp_stable got %0d changes exp 0", unstable); end
      if (pass == 1 && got_seq.size() > 0) begin
        n_checks++; if (got_seq[0] !== 16'h0180) begin n_fail++; $display("FAIL bp_seq2 got %h exp 0180", got_seq[0]); end
      end
      exp_q.delete();
    end
  endtask

  task automatic test_wrap();
    req_t q; bit ok;
    for (int k = 0; k < 257; k++) begin
      q = rand_req(2'd1, 8'h01);
      model_req(q);
      send_req(q, ok);
      collect(1, 0, 10);
      n_checks++; if (!ok || timeout) begin n_fail++; $display("FAIL wrap_handshake%0d ok=%b timeout=%b", k, ok, timeout); end
      else begin
        n_checks++; if (got_q[0] !== exp_q[0]) begin n_fail++; $display("FAIL wrap_beat%0d got %h exp %h", k, got_q[0], exp_q[0]); end
        n_checks++; if (got_seq[0] !== 16'(((k % 256) << 8) | 128)) begin n_fail++; $display("FAIL wrap_seq%0d got %h exp %h", k, got_seq[0], 16'(((k % 256) << 8) | 128)); end
      end
      exp_q.delete();
    end
  endtask

  task automatic test_bad_cc();
    req_t q; bit ok; int errs, vals, nrdy;
    for (int t = 0; t < 2; t++) begin
      q = (t == 0) ? rand_req(2'd3, 8'hFF) : rand_req(2'd0, 8'h00);
      send_req(q, ok);
      errs = 0; vals = 0; nrdy = 0;
      for (int i = 0; i < 8; i++) begin
        @(negedge clk);
        errs += int'(err); vals += int'(c.avst_source_c_valid); nrdy += int'(!r.req_ready);
      end
      n_checks++; if (!ok) begin n_fail++; $display("FAIL drop%0d_handshake got 0 exp 1", t); end
      n_checks++; if (errs !== ((t == 0) ? 1 : 0)) begin n_fail++; $display("FAIL drop%0d_err got %0d cycles exp %0d", t, errs, (t == 0) ? 1 : 0); end
      n_checks++; if (vals !== 0) begin n_fail++; $display("FAIL drop%0d_beats got %0d exp 0", t, vals); end
      n_checks++; if (nrdy !== 0) begin n_fail++; $display("FAIL drop%0d_ready got %0d low cycles exp 0", t, nrdy); end
    end
  endtask

  task automatic test_fields();
    req_t q; bit ok;
    q = rand_req(2'd0, 8'h01);
    q.toff = 16'h1234; q.cp = 16'h0320; q.fo = 24'hFFF000; q.ns = 4'd1;
    model_req(q);
    c.avst_source_c_ready = 1'b0;
    send_req(q, ok);
    @(negedge clk);
    n_checks++; if (c.avst_source_c_valid !== 1'b1) begin n_fail++; $display("FAIL fld_valid got %b exp 1", c.avst_source_c_valid); end
    n_checks++; if (c.tx_c_timeOffset !== 16'h1234 || c.tx_c_cpLength !== 16'h0320)
      begin n_fail++; $display("FAIL fld_hdr got %h/%h exp 1234/0320", c.tx_c_timeOffset, c.tx_c_cpLength); end
    n_checks++; if (c.tx_c_freqOffset !== 24'hFFF000 || c.tx_c_numSymbol !== 4'd1)
      begin n_fail++; $display("FAIL fld_sec got %h/%h exp fff000/1", c.tx_c_freqOffset, c.tx_c_numSymbol); end
    n_checks++; if (c.tx_c_sectionType !== 8'd3 || c.tx_c_filterIndex !== 4'd1 || c.tx_c_dataDirection !== 1'b0)
      begin n_fail++; $display("FAIL fld_const got %h/%h/%b exp 03/1/0", c.tx_c_sectionType, c.tx_c_filterIndex, c.tx_c_dataDirection); end
    collect(1, 0, 10);
    n_checks++; if (!ok || timeout || got_q[0] !== exp_q[0]) begin n_fail++; $display("FAIL fld_beat got %h exp %h", dut_snap(), exp_q[0]); end
    exp_q.delete();
  endtask

  task automatic test_random();
    req_t q; bit ok; int n;
    for (int t = 0; t < 25; t++) begin
      q = rand_req(2'($urandom_range(0, 2)), 8'($urandom));
      model_req(q);
      n = exp_q.size();
      send_req(q, ok);
      collect(n, 2, 60);
      n_checks++; if (!ok || timeout) begin n_fail++; $display("FAIL rand%0d_handshake ok=%b timeout=%b", t, ok, timeout); end
      for (int k = 0; k < got_q.size(); k++) begin
        n_checks++; if (got_q[k] !== exp_q[k]) begin n_fail++; $display("FAIL rand%0d_beat%0d got %h exp %h", t, k, got_q[k], exp_q[k]); end
      end
      n_checks++; if (unstable !== 0 || after_ready !== 1'b1) begin n_fail++; $display("FAIL rand%0d_stall got changes=%0d ready=%b exp 0/1", t, unstable, after_ready); end
      exp_q.delete();
    end
  endtask

  task automatic test_reset_mid();
    req_t q; bit ok;
    q = rand_req(2'd0, 8'hFF);
    model_req(q);
    send_req(q, ok);
    collect(2, 0, 10);
    #2 rst = 1'b1;
    #1;
    n_checks++; if (c.avst_source_c_valid !== 1'b0 || r.req_ready !== 1'b0)
      begin n_fail++; $display("FAIL rstmid_drop got valid=%b ready=%b exp 0/0", c.avst_source_c_valid, r.req_ready); end
    for (int k = 0; k < got_q.size(); k++) begin
      n_checks++; if (got_q[k] !== exp_q[k]) begin n_fail++; $display("FAIL rstmid_beat%0d got %h exp %h", k, got_q[k], exp_q[k]); end
    end
    exp_q.delete();
    for (int cc = 0; cc < 3; cc++) for (int a = 0; a < 8; a++) mcnt[cc][a] = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    q = rand_req(2'd0, 8'h03);
    model_req(q);
    send_req(q, ok);
    collect(2, 0, 10);
    n_checks++; if (!ok || timeout) begin n_fail++; $display("FAIL rstmid_restart ok=%b timeout=%b", ok, timeout); end
    for (int k = 0; k < got_q.size(); k++) begin
      n_checks++; if (got_q[k] !== exp_q[k] || got_seq[k] !== 16'h0080)
        begin n_fail++; $display("FAIL rstmid_after%0d got %h exp %h", k, got_q[k], exp_q[k]); end
    end
    exp_q.delete();
  endtask

  initial begin
    for (int cc = 0; cc < 3; cc++) for (int a = 0; a < 8; a++) mcnt[cc][a] = 0;
    test_reset();
    test_basic();
    test_backpressure();
    test_wrap();
    test_bad_cc();
    test_fields();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog expired exp completion before 600000");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/prach_c_plane_tx.md
Name: prach_c_plane_tx

Overview:
Generates O-RAN C-plane Section Type 3 (PRACH) messages, one per enabled antenna, toward the eCPRI/xRAN framer. This is the transmit counterpart of the PRACH C-plane receiver. A scheduler issues one request per PRACH occasion and CC. The block expands the request over an 8-bit antenna mask, maps each (CC, antenna) to its RTC ID, maintains a per-eAxC sequence counter, and emits single-beat Avalon-ST field messages under ready/valid backpressure.

Parameters:
- FRAME_STRUCTURE, 8'hC1, constant driven on tx_c_frameStructure.
- UD_COMP_HDR, 8'h00, constant driven on tx_c_udCompHdr.
- PAYLOAD_VERSION, 3'd1, constant driven on tx_c_payloadVersion.

Ports:
- clk  in  1  clk_eth_xran domain
- rst  in  1  asynchronous, active-high reset
- req_valid  in  1  request strobe
- req_ready  out  1  block can accept a request
- req_cc  in  2  carrier 0..2; value 3 is illegal
- req_ant_mask  in  8  bit a = emit a message for antenna a
- req_frameId, req_subframeId, req_slotId, req_symbolId  in  8/4/6/6  timing fields
- req_timeOffset, req_cpLength  in  16/16  Section Type 3 common header fields
- req_sectionId, req_startPrbc, req_numPrbc, req_numSymbol  in  12/10/8/4  section fields
- req_beamid, req_freqOffset  in  15/24  section fields
- avst_source_c_valid  out  1; avst_source_c_ready  in  1
- avst_source_c_startofpacket, avst_source_c_endofpacket  out  1/1
- tx_c_rtc_id, tx_c_seq_id  out  16/16
- tx_c_dataDirection, tx_c_payloadVersion, tx_c_filterIndex, tx_c_sectionType  out  1/3/4/8
- tx_c_frameId … tx_c_freqOffset  out  same widths as the req_* fields; tx_c_frameStructure, tx_c_udCompHdr 8/8; tx_c_rb, tx_c_symInc, tx_c_ef 1 each; tx_c_reMask 12
- err_bad_cc  out  1  one-cycle pulse when a request with req_cc==3 is dropped

Behaviour:
- Reset (async, rst=1):
  - FSM goes to IDLE.
  - req_ready=0 while rst is asserted, then 1 from the first clock after deassertion.
  - avst_source_c_valid=0, err_bad_cc=0, all 24 sequence counters=0, all tx_c_* outputs=0.
- Reset mid-message drops the message and all pending antennas immediately. Nothing is replayed.
- FSM states: IDLE, SEND.
- IDLE:
  - req_ready=1.
  - On req_valid, latch all req_* fields and the mask.
  - If req_cc==3: pulse err_bad_cc the next cycle and stay in IDLE.
  - If the mask is 0: stay in IDLE and emit nothing.
  - Otherwise go to SEND.
- SEND:
  - req_ready=0.
  - The current antenna is the lowest set bit of the remaining mask.
  - avst_source_c_valid=1 from the cycle after acceptance; first-beat latency is 1 cycle.
  - On valid&&ready: clear that mask bit and increment that eAxC's counter (8-bit, wraps 255→0).
  - When the last bit clears, return to IDLE. req_ready=1 in the following cycle.
  - With ready held high, throughput is 1 message per cycle.
- Backpressure: while valid&&!ready, every tx_c_* output and the SOP/EOP flags stay stable.
- Each message is one beat: startofpacket=endofpacket=valid.
- RTC ID for (cc, ant): {4'h0, 3'b0, ant[2], cc[1:0]… } laid out as DU_ID=0, Band_Sector=ant[2], CC_ID=cc, Ant_ID=ant[1:0]. Examples:
  - cc1/ant0 → 16'h0010
  - cc2/ant6 → 16'h0122
  - cc0/ant7 → 16'h0103
- tx_c_seq_id = {counter[cc][ant], 1'b1 (E bit), 7'd0}. The value carried is the counter before increment.
- Constant fields:
  - dataDirection=0 (UL), filterIndex=4'b0001, sectionType=8'd3
  - rb=0, symInc=0, ef=0, reMask=12'hFFF
  - frameStructure, udCompHdr and payloadVersion come from the parameters.
- All other tx_c_* fields come from the latched request, which is identical for every antenna in the burst.
- A request is not accepted while in SEND. The scheduler holds req_valid until req_ready is seen.

Test Plan:
- Reset, then request cc=0, mask=8'h0F, ready=1 → 4 beats on consecutive cycles with rtc_id 0000,0001,0002,0003 and seq_id 16'h0080 each. req_ready=1 again 1 cycle after the last beat.
- cc=2, mask=8'hA0, ready toggling 1/0 every cycle → beats 0121 then 0123. Fields stay stable through the stall cycles; the second message for (2,5) carries seq_id 16'h0180.
- 257 requests for cc=1, mask=8'h01 → seq byte runs 0..255, and the 257th message shows 0 (wrap).
- req_cc=3, mask=8'hFF → no beats, err_bad_cc high for exactly 1 cycle, req_ready stays 1. mask=0 with cc=0 → no beats, no error.
- rst asserted asynchronously after 2 of 8 beats → valid drops immediately and counters clear. The next request restarts at seq 0 from ant0.
- Field check: timeOffset=16'h1234, cpLength=16'h0320, freqOffset=24'hFFF000, numSymbol=1 → fields reproduced exactly, sectionType=3, filterIndex=1, dataDirection=0.
